// File: rtl/acc_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_sched_pkg
//  Description : Shared types and default parameter values for the
//                accumulator job scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package acc_sched_pkg;

    localparam int NUM_REQ_DEF     = 4;
    localparam int DIN_WIDTH_DEF   = 32;
    localparam int DOUT_WIDTH_DEF  = 32;
    localparam int LEN_WIDTH_DEF   = 8;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/acc_sched_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin request selector. The requester at index
//                'pointer' has highest priority, priority then wraps upward.
//                Output is one-hot, or all-zero when nothing is requested.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant
);

    // Scan requesters starting at the pointer; the first one found wins.
    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(pointer) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/acc_sched.sv
`default_nettype none
// ============================================================================
//  Module      : acc_sched
//  Description : Grants one requester at a time access to an external
//                accumulator, streams its samples through, and returns the
//                registered result with a done pulse.
//                Optional stall watchdog: define ACC_SCHED_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_sched
    import acc_sched_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int DIN_WIDTH   = DIN_WIDTH_DEF,
    parameter int DOUT_WIDTH  = DOUT_WIDTH_DEF,
    parameter int LEN_WIDTH   = LEN_WIDTH_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                                clk,
    input  logic                                rst_ni,
    input  logic [NUM_REQ-1:0]                  req_i,
    input  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]   len_i,
    input  logic [NUM_REQ-1:0]                  valid_i,
    input  logic [NUM_REQ-1:0][DIN_WIDTH-1:0]   data_i,
    output logic [NUM_REQ-1:0]                  ready_o,
    output logic [NUM_REQ-1:0]                  grant_o,
    output logic [NUM_REQ-1:0]                  done_o,
    output logic                                err_o,
    output logic signed [DOUT_WIDTH-1:0]        result_o,
    output logic                                acc_en_o,
    output logic                                acc_clear_o,
    output logic signed [DIN_WIDTH-1:0]         acc_data_o,
    input  logic signed [DOUT_WIDTH-1:0]        acc_result_i,
    output logic                                busy_o
);

    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e                  state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [PTR_W-1:0]        owner_q, owner_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [NUM_REQ-1:0]      done_q, done_d;
    logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DOUT_WIDTH-1:0]   result_q, result_d;
    logic [NUM_REQ-1:0]      arb_grant;
    logic [PTR_W-1:0]        arb_idx;
    logic                    beat;

`ifdef ACC_SCHED_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [STALL_W-1:0]      stall_q, stall_d;
    logic                    tmo_q, tmo_d;
    logic                    err_q, err_d;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req     (req_i),
        .pointer (ptr_q),
        .grant   (arb_grant)
    );

    // Binary index of the arbiter winner, used for muxing and pointer update.
    always_comb begin
        arb_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) arb_idx = PTR_W'(i);
        end
    end

    // Datapath handshake: only the owner sees ready, and only in STREAM.
    assign beat        = (state_q == ST_STREAM) && valid_i[owner_q];
    assign ready_o     = (state_q == ST_STREAM) ? grant_q : '0;
    assign acc_en_o    = beat;
    assign acc_data_o  = beat ? data_i[owner_q] : '0;
    assign acc_clear_o = (state_q == ST_CLEAR);
    assign busy_o      = (state_q != ST_IDLE);
    assign grant_o     = grant_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
`ifdef ACC_SCHED_TIMEOUT_EN
    assign err_o       = err_q;
`else
    assign err_o       = 1'b0;
`endif

    // Next-state and job bookkeeping.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        grant_d  = grant_q;
        done_d   = '0;
        cnt_d    = cnt_q;
        result_d = result_q;
`ifdef ACC_SCHED_TIMEOUT_EN
        stall_d  = '0;
        tmo_d    = tmo_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req_i) begin
                    grant_d = arb_grant;
                    owner_d = arb_idx;
                    cnt_d   = len_i[arb_idx];
                    ptr_d   = (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                    state_d = ST_CLEAR;
`ifdef ACC_SCHED_TIMEOUT_EN
                    tmo_d   = 1'b0;
`endif
                end
            end
            ST_CLEAR: begin
                state_d = (cnt_q == '0) ? ST_DRAIN : ST_STREAM;
            end
            ST_STREAM: begin
                if (beat) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_WIDTH'(1)) state_d = ST_DRAIN;
                end
`ifdef ACC_SCHED_TIMEOUT_EN
                else if (stall_q == STALL_W'(TIMEOUT_CYC - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = ST_DRAIN;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
            // The accumulator output lags en/clear by a cycle.
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                result_d = acc_result_i;
                done_d   = grant_q;
                grant_d  = '0;
                state_d  = ST_IDLE;
`ifdef ACC_SCHED_TIMEOUT_EN
                err_d    = tmo_q;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any job in flight.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
`ifdef ACC_SCHED_TIMEOUT_EN
            stall_q  <= '0;
            tmo_q    <= 1'b0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
`ifdef ACC_SCHED_TIMEOUT_EN
            stall_q  <= stall_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_acc_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_sched
//  Description : Self-checking bench for acc_sched with an external
//                accumulator model and a round-robin/sum reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_sched;

    localparam int NR  = 4;
    localparam int DW  = 32;
    localparam int OW  = 32;
    localparam int LW  = 8;
    localparam int TMO = 8;

    logic                       clk = 1'b0;
    logic                       rst_ni;
    logic [NR-1:0]              req_i;
    logic [NR-1:0][LW-1:0]      len_i;
    logic [NR-1:0]              valid_i;
    logic [NR-1:0][DW-1:0]      data_i;
    logic [NR-1:0]              ready_o, grant_o, done_o;
    logic                       err_o;
    logic signed [OW-1:0]       result_o;
    logic                       acc_en_o, acc_clear_o;
    logic signed [DW-1:0]       acc_data_o;
    logic signed [OW-1:0]       acc_result_i;
    logic                       busy_o;

    int n_pass  = 0;
    int n_total = 0;
    int rr_ptr  = 0;
    logic signed [DW-1:0] smp [16];

    acc_sched #(
        .NUM_REQ     (NR),
        .DIN_WIDTH   (DW),
        .DOUT_WIDTH  (OW),
        .LEN_WIDTH   (LW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .len_i        (len_i),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .grant_o      (grant_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .result_o     (result_o),
        .acc_en_o     (acc_en_o),
        .acc_clear_o  (acc_clear_o),
        .acc_data_o   (acc_data_o),
        .acc_result_i (acc_result_i),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // External accumulator: clear wins, result visible one cycle later.
    logic signed [OW-1:0] acc_q;
    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni)          acc_q <= '0;
        else if (acc_clear_o) acc_q <= '0;
        else if (acc_en_o)    acc_q <= acc_q + OW'(acc_data_o);
    end
    assign acc_result_i = acc_q;

    a_acc_clear: assert property (@(posedge clk) disable iff (!rst_ni)
                                  acc_clear_o |=> (acc_result_i == '0))
        else $error("FAIL acc_clear_sva acc_result_i=%0h required=0", acc_result_i);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference round-robin choice: first pending requester at or after ptr.
    function automatic int rr_pick(input logic [3:0] mask, input int ptr);
        for (int i = 0; i < 4; i++) begin
            int c;
            c = (ptr + i) % 4;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    // One job for requester 'own'. Cycles are counted from the arbitration
    // cycle in IDLE, so the first cycle showing grant_o is t=1.
    task automatic run_job(input logic [3:0] mask, input int own, input bit hold,
                           input int stall_after, input int stall_cyc,
                           input bit rand_stall, input bit exp_err);
        int n, t, b, stalls, idle, consec, len, nsum, exp_t;
        logic signed [OW-1:0] exp_res;
        bit v, rdy;
        len  = int'(len_i[own]);
        nsum = exp_err ? stall_after : len;
        exp_res = '0;
        for (int k = 0; k < nsum; k++) exp_res = exp_res + OW'(smp[k]);
        valid_i = '0;
        req_i   = mask;
        n = 0;
        while (grant_o == '0 && n < 50) begin @(posedge clk); #1; n++; end
        check("grant_owner", 64'(grant_o), 64'(4'b0001 << own));
        if (!hold) req_i = '0;
        rr_ptr = (own + 1) % 4;
        t = 1; b = 0; stalls = 0; idle = 0; consec = 0;
        while (done_o == '0 && t < 400) begin
            v = (b < len);
            if (b == stall_after && stalls < stall_cyc) v = 1'b0;
            if (rand_stall && consec < 3 && $urandom_range(0, 2) == 0) v = 1'b0;
            for (int k = 0; k < NR; k++) data_i[k] = $urandom;
            if (b < len) data_i[own] = smp[b];
            valid_i[own] = v;
            #1;
            rdy = ready_o[own];
            check("ready_others", 64'(ready_o & ~(4'b0001 << own)), 64'(0));
            check("acc_en", 64'(acc_en_o), 64'(rdy & v));
            check("acc_data", 64'(acc_data_o), (rdy && v) ? 64'(smp[b]) : 64'(0));
            check("busy_job", 64'(busy_o), 64'(1));
            if (rdy && v) begin
                b++;
                consec = 0;
            end else if (rdy) begin
                idle++;
                consec++;
                if (b == stall_after) stalls++;
            end
            @(posedge clk); #1; t++;
        end
        exp_t = exp_err ? (stall_after + TMO + 4) : (len + 4 + idle);
        check("done_time", 64'(t), 64'(exp_t));
        check("done_onehot", 64'(done_o), 64'(4'b0001 << own));
        check("err", 64'(err_o), 64'(exp_err));
        check("result", 64'(result_o), 64'(exp_res));
        check("grant_cleared", 64'(grant_o), 64'(0));
        valid_i = '0;
        @(posedge clk); #1;
        check("done_pulse_width", 64'(done_o), 64'(0));
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        logic [3:0] mask;
        int own, n;
        req_i = '0; valid_i = '0; len_i = '0; data_i = '0; rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant",  64'(grant_o),     64'(0));
        check("rst_ready",  64'(ready_o),     64'(0));
        check("rst_done",   64'(done_o),      64'(0));
        check("rst_err",    64'(err_o),       64'(0));
        check("rst_result", 64'(result_o),    64'(0));
        check("rst_acc_en", 64'(acc_en_o),    64'(0));
        check("rst_clear",  64'(acc_clear_o), 64'(0));
        check("rst_busy",   64'(busy_o),      64'(0));
        rst_ni = 1'b1;
        rr_ptr = 0;
        @(posedge clk); #1;

        // Requester 0: 5, -2, 7 -> 10
        smp[0] = 32'sd5; smp[1] = -32'sd2; smp[2] = 32'sd7;
        len_i[0] = 8'd3;
        run_job(4'b0001, 0, 1'b0, -1, 0, 1'b0, 1'b0);

        // Zero-length job
        len_i[1] = 8'd0;
        run_job(4'b0010, 1, 1'b0, -1, 0, 1'b0, 1'b0);

`ifdef ACC_SCHED_TIMEOUT_EN
        // Watchdog abort after one beat of 100
        smp[0] = 32'sd100;
        for (int k = 1; k < 4; k++) smp[k] = $urandom;
        len_i[2] = 8'd4;
        run_job(4'b0100, 2, 1'b0, 1, 20, 1'b0, 1'b1);
`else
        // Ten-cycle stall mid-job waits it out
        for (int k = 0; k < 4; k++) smp[k] = $urandom;
        len_i[2] = 8'd4;
        run_job(4'b0100, 2, 1'b0, 2, 10, 1'b0, 1'b0);
`endif

        // Random request sets, lengths, data and short stalls
        for (int j = 0; j < 12; j++) begin
            mask = 4'($urandom_range(1, 15));
            for (int k = 0; k < NR; k++) len_i[k] = LW'($urandom_range(0, 5));
            for (int k = 0; k < 6; k++) smp[k] = $urandom;
            own = rr_pick(mask, rr_ptr);
            run_job(mask, own, 1'b0, -1, 0, 1'b1, 1'b0);
        end

        // Reset in the middle of STREAM
        len_i[2] = 8'd5;
        req_i = 4'b0100;
        n = 0;
        while (grant_o == '0 && n < 50) begin @(posedge clk); #1; n++; end
        req_i = '0;
        valid_i[2] = 1'b1;
        data_i[2] = 32'd3;
        repeat (3) begin @(posedge clk); #1; end
        check("pre_rst_ready", 64'(ready_o), 64'(4'b0100));
        check("pre_rst_acc_en", 64'(acc_en_o), 64'(1));
        rst_ni = 1'b0;
        #1;
        check("mid_rst_grant",  64'(grant_o),     64'(0));
        check("mid_rst_ready",  64'(ready_o),     64'(0));
        check("mid_rst_done",   64'(done_o),      64'(0));
        check("mid_rst_err",    64'(err_o),       64'(0));
        check("mid_rst_result", 64'(result_o),    64'(0));
        check("mid_rst_acc_en", 64'(acc_en_o),    64'(0));
        check("mid_rst_data",   64'(acc_data_o),  64'(0));
        check("mid_rst_clear",  64'(acc_clear_o), 64'(0));
        check("mid_rst_busy",   64'(busy_o),      64'(0));
        valid_i = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst_ni = 1'b1;
        rr_ptr = 0;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_done_after_rst", 64'(done_o), 64'(0));
        end

        // All four requesting and holding: grants go 0,1,2,3,0
        for (int k = 0; k < NR; k++) len_i[k] = 8'd1;
        smp[0] = $urandom;
        for (int j = 0; j < 5; j++) begin
            run_job(4'b1111, j % 4, (j < 4), -1, 0, 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acc_sched.md
ACC_SCHED -- requirements
Module: acc_sched

Interface
REQ-001 SHALL have parameters (name, default, meaning): NUM_REQ, 4, requester count; DIN_WIDTH, 32, sample width; DOUT_WIDTH, 32, accumulator result width; LEN_WIDTH, 8, job-length width; TIMEOUT_CYC, 64, stall watchdog limit in cycles.
REQ-002 SHALL have ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock, all logic on its rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  NUM_REQ  per-requester job request, level.
- len_i  in  NUM_REQ x LEN_WIDTH  per-requester sample count, sampled at grant.
- valid_i  in  NUM_REQ  per-requester sample valid.
- data_i  in  NUM_REQ x DIN_WIDTH, signed  per-requester sample.
- ready_o  out  NUM_REQ  per-requester sample ready.
- grant_o  out  NUM_REQ  one-hot current job owner.
- done_o  out  NUM_REQ  one-cycle job-complete pulse to owner.
- err_o  out  1  qualifies done_o: job aborted by watchdog.
- result_o  out  DOUT_WIDTH, signed  job result, held until next done.
- acc_en_o, acc_clear_o  out  1 each  accumulator enable and clear.
- acc_data_o  out  DIN_WIDTH, signed  accumulator input sample.
- acc_result_i  in  DOUT_WIDTH, signed  accumulator output.
- busy_o  out  1  high in every state except IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, CLEAR, STREAM, DRAIN, DONE.
REQ-004 IDLE: when any req_i is high, SHALL grant round-robin starting at the index after the last grant, latch len_i of the winner, set grant_o, and go to CLEAR.
REQ-005 CLEAR: SHALL assert acc_clear_o for exactly one cycle with acc_en_o low; then go to STREAM, or to DRAIN if the latched length is 0.
REQ-006 STREAM: SHALL drive ready_o high for the owner only; ready_o SHALL be low for all other requesters in every state.
REQ-007 A beat SHALL be accepted on valid_i & ready_o of the owner; in that cycle acc_en_o is 1 and acc_data_o is the owner's data_i (combinational), and the remaining count decrements.
REQ-008 acc_en_o SHALL be 0 in every cycle without an accepted beat; acc_data_o SHALL be 0 when acc_en_o is 0.
REQ-009 After the last beat is accepted, SHALL go to DRAIN for one cycle (accumulator result lags en/clear by one cycle), then to DONE.
REQ-010 DONE: SHALL register acc_result_i into result_o, pulse done_o of the owner for one cycle, clear grant_o, and return to IDLE.
REQ-011 Grant latency: a request arriving in IDLE SHALL see grant_o and acc_clear_o in the next cycle; job completion for length L with no stalls SHALL take L+4 cycles from grant.
REQ-012 Deasserting req_i during a job SHALL NOT abort it; the job always runs to completion.
REQ-013 At most one new grant SHALL be made per visit to IDLE; a requester holding req_i across its own done SHALL wait behind all other pending requesters.
REQ-014 result_o SHALL NOT be width-extended or saturated; it equals acc_result_i bit-for-bit.

Reset
REQ-015 On rst_ni low, SHALL asynchronously force state IDLE, and all outputs to 0, including grant_o, ready_o, done_o, err_o, result_o, acc_en_o, acc_clear_o and busy_o.
REQ-016 Reset SHALL set the round-robin pointer so that requester 0 has first priority.
REQ-017 Reset mid-job SHALL drop the job silently, with no done_o pulse.

Configuration
REQ-018 With ACC_SCHED_TIMEOUT_EN defined, TIMEOUT_CYC consecutive STREAM cycles without an accepted beat SHALL go to DRAIN, then to DONE with done_o and err_o high for one cycle, and result_o set to the partial sum.
REQ-019 Without ACC_SCHED_TIMEOUT_EN, no watchdog counter SHALL exist, err_o SHALL be tied to 0, and STREAM SHALL wait indefinitely.

Structure
REQ-020 Package acc_sched_pkg SHALL hold the FSM state enum typedef and the default parameter constants.
REQ-021 Round-robin selection SHALL be a sub-module named rr_arbiter, with inputs req and pointer and a one-hot grant output.

Verification
REQ-022 The bench SHALL cover these directed scenarios, and SHALL bind the accumulator SVA clear check to acc_clear_o/acc_result_i:
- Requester 0 job, len=3, data 5, -2, 7 with no stalls -> result_o=10, done_o[0] pulses 7 cycles after grant.
- req_i=4'b1111 held -> grants in order 0, 1, 2, 3, 0, each grant one-hot.
- len=0 job -> acc_clear_o pulse, acc_en_o never high, result_o=0, done pulse.
- Owner drops valid_i for 10 cycles mid-job with macro off -> no error, final sum correct.
- Macro on, TIMEOUT_CYC=8, stall after 1 beat of 100 -> done_o and err_o pulse, result_o=100.
- rst_ni low mid-STREAM -> all outputs 0 immediately, no done_o, and the next grant goes to requester 0.
